// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive path: state encoding, default
// frame geometry and the counter-width helper.
package uart_pkg;

    localparam int OVERSAMPLE_DEF = 16;
    localparam int DATA_BITS_DEF  = 8;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4,
        ST_DONE   = 3'd5
    } rx_state_t;

    // Width of a counter holding 0..count-1, never narrower than one bit.
    function automatic int cnt_width(input int count);
        return (count <= 2) ? 1 : $clog2(count);
    endfunction

    localparam int TICK_W_DEF = cnt_width(OVERSAMPLE_DEF);

endpackage

// File: rtl/uart_rx_controller_if.sv
// Signal bundle between the receive controller and the surrounding UART
// (line input, sample tick, shift-register handshake and received-byte report).
interface uart_rx_controller_if
    import uart_pkg::*;
#(
    parameter int DATA_BITS = DATA_BITS_DEF
) ();

    logic                 Rx_EN;
    logic                 RxD;
    logic                 Rx_sample_ENABLE;
    logic [DATA_BITS-1:0] shift_data_in;
    logic                 shiftEnable;
    logic                 data;
    logic [DATA_BITS-1:0] Rx_DATA;
    logic                 Rx_VALID;
    logic                 Rx_FERROR;
    logic                 Rx_PERROR;
    logic                 busy;

    modport master (
        output Rx_EN, RxD, Rx_sample_ENABLE, shift_data_in,
        input  shiftEnable, data, Rx_DATA, Rx_VALID, Rx_FERROR, Rx_PERROR, busy
    );

    modport slave (
        input  Rx_EN, RxD, Rx_sample_ENABLE, shift_data_in,
        output shiftEnable, data, Rx_DATA, Rx_VALID, Rx_FERROR, Rx_PERROR, busy
    );

endinterface

// File: rtl/uart_rx_sync.sv
// Two-flop synchroniser for the asynchronous serial line; resets to the
// idle (high) level so no false start is seen after reset.
module uart_rx_sync (
    input  logic clk,
    input  logic reset,
    input  logic async_line,
    output logic sync_line
);

    logic [1:0] sync_reg;

    always_ff @(posedge clk) begin
        if (reset) begin
            sync_reg <= 2'b11;
        end else begin
            sync_reg <= {sync_reg[0], async_line};
        end
    end

    assign sync_line = sync_reg[1];

endmodule

// File: rtl/uart_rx_controller.sv
// UART receive control FSM: start detection, mid-bit sampling, parity/stop
// checks and byte report. Define UART_RX_MAJORITY_VOTE_EN for 2-of-3 voting.
module uart_rx_controller
    import uart_pkg::*;
#(
    parameter int OVERSAMPLE = OVERSAMPLE_DEF,
    parameter int DATA_BITS  = DATA_BITS_DEF,
    parameter int PARITY_ODD = 0
) (
    input logic           clk,
    input logic           reset,
    uart_rx_controller_if.slave bus
);

    localparam int TW = cnt_width(OVERSAMPLE);
    localparam int BW = cnt_width(DATA_BITS + 1);

    localparam logic [TW-1:0] TICK_LAST = TW'(OVERSAMPLE - 1);
    localparam logic [BW-1:0] LAST_BIT  = BW'(DATA_BITS - 1);
    localparam logic          ODD_BIT   = (PARITY_ODD != 0);

`ifdef UART_RX_MAJORITY_VOTE_EN
    // Decision one tick after the centre; a good start bit is held until the
    // counter wraps so data bits keep centre = OVERSAMPLE/2-1.
    localparam logic [TW-1:0] START_DEC  = TW'(OVERSAMPLE / 2);
    localparam logic [TW-1:0] START_EXIT = TICK_LAST;
    localparam logic [TW-1:0] BIT_DEC    = TW'(OVERSAMPLE / 2);
    localparam logic [TW-1:0] VOTE_A_CNT = TW'(OVERSAMPLE / 2 - 2);
    localparam logic [TW-1:0] VOTE_B_CNT = TW'(OVERSAMPLE / 2 - 1);
`else
    localparam logic [TW-1:0] START_DEC  = TW'(OVERSAMPLE / 2 - 1);
    localparam logic [TW-1:0] START_EXIT = START_DEC;
    localparam logic [TW-1:0] BIT_DEC    = TICK_LAST;
`endif

    rx_state_t            state_reg, state_next;
    logic [TW-1:0]        tick_cnt_reg, tick_cnt_next, tick_cnt_inc;
    logic [BW-1:0]        bit_cnt_reg, bit_cnt_next;
    logic                 parity_reg, parity_next;
    logic                 perr_reg, perr_next;
    logic                 ferr_reg, ferr_next;
    logic [DATA_BITS-1:0] rx_data_reg;
    logic                 rx_ferror_reg, rx_perror_reg;
    logic                 rxs, sample_bit, tick, enable;

    assign tick   = bus.Rx_sample_ENABLE;
    assign enable = bus.Rx_EN;

    uart_rx_sync u_sync (
        .clk        (clk),
        .reset      (reset),
        .async_line (bus.RxD),
        .sync_line  (rxs)
    );

`ifdef UART_RX_MAJORITY_VOTE_EN
    logic vote_a_reg, vote_b_reg;

    always_ff @(posedge clk) begin
        if (reset) begin
            vote_a_reg <= 1'b1;
            vote_b_reg <= 1'b1;
        end else if (tick) begin
            if (tick_cnt_reg == VOTE_A_CNT) vote_a_reg <= rxs;
            if (tick_cnt_reg == VOTE_B_CNT) vote_b_reg <= rxs;
        end
    end

    assign sample_bit = (vote_a_reg & vote_b_reg) | (vote_a_reg & rxs) | (vote_b_reg & rxs);
`else
    assign sample_bit = rxs;
`endif

    assign tick_cnt_inc = (tick_cnt_reg == TICK_LAST) ? '0 : tick_cnt_reg + 1'b1;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg     <= ST_IDLE;
            tick_cnt_reg  <= '0;
            bit_cnt_reg   <= '0;
            parity_reg    <= 1'b0;
            perr_reg      <= 1'b0;
            ferr_reg      <= 1'b0;
            rx_data_reg   <= '0;
            rx_ferror_reg <= 1'b0;
            rx_perror_reg <= 1'b0;
        end else begin
            state_reg    <= state_next;
            tick_cnt_reg <= tick_cnt_next;
            bit_cnt_reg  <= bit_cnt_next;
            parity_reg   <= parity_next;
            perr_reg     <= perr_next;
            ferr_reg     <= ferr_next;
            if (state_reg == ST_DONE && enable) begin
                rx_data_reg   <= bus.shift_data_in;
                rx_ferror_reg <= ferr_reg;
                rx_perror_reg <= perr_reg;
            end
        end
    end

    always_comb begin
        state_next    = state_reg;
        tick_cnt_next = tick_cnt_reg;
        bit_cnt_next  = bit_cnt_reg;
        parity_next   = parity_reg;
        perr_next     = perr_reg;
        ferr_next     = ferr_reg;
        if (!enable) begin
            state_next    = ST_IDLE;
            tick_cnt_next = '0;
            bit_cnt_next  = '0;
            parity_next   = 1'b0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    tick_cnt_next = '0;
                    if (tick && !rxs) begin
                        state_next   = ST_START;
                        bit_cnt_next = '0;
                        parity_next  = 1'b0;
                    end
                end
                ST_START: begin
                    if (tick) begin
                        tick_cnt_next = tick_cnt_inc;
                        if (tick_cnt_reg == START_DEC && sample_bit) begin
                            state_next    = ST_IDLE;
                            tick_cnt_next = '0;
                        end else if (tick_cnt_reg == START_EXIT) begin
                            state_next    = ST_DATA;
                            tick_cnt_next = '0;
                            bit_cnt_next  = '0;
                            parity_next   = 1'b0;
                        end
                    end
                end
                ST_DATA: begin
                    if (tick) begin
                        tick_cnt_next = tick_cnt_inc;
                        if (tick_cnt_reg == BIT_DEC) begin
                            parity_next  = parity_reg ^ sample_bit;
                            bit_cnt_next = bit_cnt_reg + 1'b1;
                            if (bit_cnt_reg == LAST_BIT) state_next = ST_PARITY;
                        end
                    end
                end
                ST_PARITY: begin
                    if (tick) begin
                        tick_cnt_next = tick_cnt_inc;
                        if (tick_cnt_reg == BIT_DEC) begin
                            perr_next  = ((parity_reg ^ sample_bit) != ODD_BIT);
                            state_next = ST_STOP;
                        end
                    end
                end
                ST_STOP: begin
                    if (tick) begin
                        tick_cnt_next = tick_cnt_inc;
                        if (tick_cnt_reg == BIT_DEC) begin
                            ferr_next  = !sample_bit;
                            state_next = ST_DONE;
                        end
                    end
                end
                ST_DONE: begin
                    state_next    = ST_IDLE;
                    tick_cnt_next = '0;
                end
                default: state_next = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        bus.shiftEnable = enable && tick && (state_reg == ST_DATA) && (tick_cnt_reg == BIT_DEC);
        bus.data        = sample_bit;
        bus.Rx_VALID    = enable && (state_reg == ST_DONE);
        bus.busy        = (state_reg != ST_IDLE);
        bus.Rx_DATA     = rx_data_reg;
        bus.Rx_FERROR   = rx_ferror_reg;
        bus.Rx_PERROR   = rx_perror_reg;
    end

endmodule

// File: tb/tb_uart_rx_controller.sv
// Directed + random frame bench for uart_rx_controller; expected bytes and
// flags come from a per-tick line array sampled by the frame rules.
module tb_uart_rx_controller;

    localparam int OS       = 16;
    localparam int DB       = 8;
    localparam int NBITS    = DB + 3;
    localparam int FSTEPS   = OS * NBITS;
    localparam bit PAR_ODD  = 1'b0;
`ifdef UART_RX_MAJORITY_VOTE_EN
    localparam bit VOTE = 1'b1;
`else
    localparam bit VOTE = 1'b0;
`endif
    // Step (tick) index, relative to frame start, where VALID is seen high.
    localparam int LAT = (DB + 2) * OS + OS / 2 + 1 + (VOTE ? 1 : 0);

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    uart_rx_controller_if #(.DATA_BITS(DB)) bus ();

    uart_rx_controller #(
        .OVERSAMPLE (OS),
        .DATA_BITS  (DB),
        .PARITY_ODD (0)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    logic [DB-1:0] shreg;
    int se_count    = 0;
    int valid_count = 0;
    int valid_step  = 0;
    int step_idx    = 0;
    int checks      = 0;
    int errors      = 0;
    bit line [FSTEPS];
    logic [DB-1:0] last_byte;

    // Downstream right-shift register, LSB-first.
    always @(posedge clk) begin
        if (reset) shreg <= '0;
        else if (bus.shiftEnable && bus.Rx_sample_ENABLE) shreg <= {bus.data, shreg[DB-1:1]};
        if (bus.shiftEnable) se_count <= se_count + 1;
        if (bus.Rx_VALID) begin
            valid_count <= valid_count + 1;
            valid_step  <= step_idx;
        end
    end
    assign bus.shift_data_in = shreg;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // One sample-tick period: line value v is what the tick at its end sees.
    task automatic step(input bit v);
        @(negedge clk);
        step_idx++;
        bus.Rx_sample_ENABLE = 1'b0;
        bus.RxD = v;
        repeat (2) @(negedge clk);
        @(negedge clk);
        bus.Rx_sample_ENABLE = 1'b1;
    endtask

    task automatic build(input logic [DB-1:0] d, input bit par, input bit stp);
        for (int b = 0; b < NBITS; b++) begin
            bit v;
            if (b == 0) v = 1'b0;
            else if (b <= DB) v = d[b-1];
            else if (b == DB + 1) v = par;
            else v = stp;
            for (int s = 0; s < OS; s++) line[b*OS + s] = v;
        end
    endtask

    function automatic bit ref_sample(input int b);
        int c;
        c = b * OS + OS / 2;
        if (VOTE) return (line[c-1] & line[c]) | (line[c-1] & line[c+1]) | (line[c] & line[c+1]);
        return line[c];
    endfunction

    task automatic frame_test(input string name, input logic [DB-1:0] d, input bit par,
                              input bit stp, input int glitch, input int gap);
        logic [DB-1:0] exp_byte;
        bit exp_perr, exp_ferr;
        int base, se0, v0;
        build(d, par, stp);
        if (glitch >= 0) line[glitch] = ~line[glitch];
        for (int b = 0; b < DB; b++) exp_byte[b] = ref_sample(b + 1);
        exp_perr = (((^exp_byte) ^ ref_sample(DB + 1)) != PAR_ODD);
        exp_ferr = !ref_sample(DB + 2);
        se0  = se_count;
        v0   = valid_count;
        base = step_idx + 1;
        for (int s = 0; s < FSTEPS; s++) step(line[s]);
        repeat (gap) step(1'b1);
        chk({name, "_valid_pulses"}, valid_count - v0, 1);
        chk({name, "_shifts"}, se_count - se0, DB);
        chk({name, "_latency"}, valid_step - base, LAT);
        chk({name, "_data"}, bus.Rx_DATA, exp_byte);
        chk({name, "_perr"}, bus.Rx_PERROR, exp_perr);
        chk({name, "_ferr"}, bus.Rx_FERROR, exp_ferr);
        if (gap > 0) chk({name, "_busy_after"}, bus.busy, 0);
        $display("frame %s: sent=0x%02h par=%0d stop=%0d -> Rx_DATA=0x%02h perr=%0d ferr=%0d",
                 name, d, par, stp, bus.Rx_DATA, bus.Rx_PERROR, bus.Rx_FERROR);
        last_byte = exp_byte;
    endtask

    initial begin
        int se0, v0;
        logic [DB-1:0] prev, d;
        bit par, stp;

        bus.Rx_EN = 1'b1;
        bus.RxD = 1'b1;
        bus.Rx_sample_ENABLE = 1'b0;
        reset = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_data", bus.Rx_DATA, 0);
        chk("rst_valid", bus.Rx_VALID, 0);
        chk("rst_ferr", bus.Rx_FERROR, 0);
        chk("rst_perr", bus.Rx_PERROR, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_shift", bus.shiftEnable, 0);
        reset = 1'b0;
        repeat (4) step(1'b1);

        frame_test("a5", 8'hA5, 1'b0, 1'b1, -1, 12);
        frame_test("3c_perr", 8'h3C, 1'b1, 1'b1, -1, 12);
        frame_test("ff_ferr", 8'hFF, 1'b0, 1'b0, -1, 12);

        // False start: three low ticks then idle.
        se0 = se_count;
        v0 = valid_count;
        repeat (3) step(1'b0);
        chk("fs_busy_mid", bus.busy, 1);
        repeat (20) step(1'b1);
        chk("fs_valid", valid_count - v0, 0);
        chk("fs_shifts", se_count - se0, 0);
        chk("fs_busy", bus.busy, 0);
        chk("fs_data_hold", bus.Rx_DATA, 8'hFF);
        $display("false start: busy=%0d data=0x%02h", bus.busy, bus.Rx_DATA);

        // Reset during data bit 4.
        build(8'h5A, 1'b0, 1'b1);
        v0 = valid_count;
        for (int s = 0; s < 5 * OS + OS / 2; s++) step(line[s]);
        chk("mr_busy_before", bus.busy, 1);
        @(negedge clk);
        bus.Rx_sample_ENABLE = 1'b0;
        bus.RxD = 1'b1;
        reset = 1'b1;
        @(negedge clk);
        chk("mr_data", bus.Rx_DATA, 0);
        chk("mr_valid", bus.Rx_VALID, 0);
        chk("mr_ferr", bus.Rx_FERROR, 0);
        chk("mr_perr", bus.Rx_PERROR, 0);
        chk("mr_busy", bus.busy, 0);
        chk("mr_shift", bus.shiftEnable, 0);
        reset = 1'b0;
        repeat (12) step(1'b1);
        chk("mr_no_valid", valid_count - v0, 0);
        $display("reset mid-frame: Rx_DATA=0x%02h busy=%0d", bus.Rx_DATA, bus.busy);
        frame_test("5a", 8'h5A, 1'b0, 1'b1, -1, 12);

        // One-tick low glitch at the centre of data bit 0.
        frame_test("glitch01", 8'h01, 1'b1, 1'b1, OS + OS / 2, 12);

        // Receiver disabled mid-frame: frame dropped, outputs held.
        prev = last_byte;
        build(8'h77, 1'b0, 1'b1);
        v0 = valid_count;
        for (int s = 0; s < FSTEPS; s++) begin
            if (s == 60) bus.Rx_EN = 1'b0;
            step(line[s]);
        end
        repeat (12) step(1'b1);
        bus.Rx_EN = 1'b1;
        repeat (4) step(1'b1);
        chk("en_valid", valid_count - v0, 0);
        chk("en_busy", bus.busy, 0);
        chk("en_data_hold", bus.Rx_DATA, prev);
        $display("rx_en drop: Rx_DATA=0x%02h busy=%0d", bus.Rx_DATA, bus.busy);

        // Back-to-back frames.
        frame_test("b2b_c3", 8'hC3, 1'b0, 1'b1, -1, 0);
        frame_test("b2b_3a", 8'h3A, 1'b0, 1'b1, -1, 12);

        for (int i = 0; i < 6; i++) begin
            d   = DB'($urandom);
            par = (^d) ^ ($urandom_range(0, 3) == 0);
            stp = ($urandom_range(0, 4) != 0);
            frame_test($sformatf("rnd%0d", i), d, par, stp, -1, 12);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
